// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the fetch front end.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam int PC_W    = 32;   // widest AW the entry type can hold
   localparam logic [PC_W-1:0] DEF_RESET_PC = '0;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               filled;
   } entry_t;
endpackage

// File: rtl/fetch_ring.sv
// DEPTH-entry prefetch storage: entries are allocated at issue, filled in order
// by memory responses and popped from the head; clear flushes everything.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               alloc,
   input  logic [AW-1:0]      alloc_pc,
   input  logic               fill,
   input  logic [INSTR_W-1:0] fill_instr,
   input  logic               pop,
   output entry_t             head,
   output logic [CW-1:0]      filled_cnt
);
   entry_t        ring [DEPTH];
   logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;

   // alloc, fill and pop always address distinct entries, so they can share a cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      end else if (clear) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i].filled <= 1'b0;
      end else begin
         if (alloc) begin
            ring[alloc_ptr] <= '{pc: PC_W'(alloc_pc), instr: '0, filled: 1'b0};
            alloc_ptr       <= alloc_ptr + PW'(1);
         end
         if (fill) begin
            ring[fill_ptr].instr  <= fill_instr;
            ring[fill_ptr].filled <= 1'b1;
            fill_ptr              <= fill_ptr + PW'(1);
         end
         if (pop) begin
            ring[head_ptr].filled <= 1'b0;
            head_ptr              <= head_ptr + PW'(1);
         end
      end
   end

   always_comb begin
      filled_cnt = '0;
      for (int i = 0; i < DEPTH; i++) filled_cnt += CW'(ring[i].filled);
   end

   assign head = ring[head_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues in-order fetches into a prefetch ring,
// and on redirect flushes the ring while counting stale responses to discard.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [AW-1:0]      imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               hold,
   input  logic               redirect_valid,
   input  logic [AW-1:0]      redirect_pc,
   input  logic               dec_ready,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [AW-1:0]      dec_pc,
   output logic [AW-1:0]      dec_pcplus4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] pc;
   logic [CW-1:0] alloc_cnt, drop_cnt, filled_cnt, unfilled;
   entry_t        head;
   logic          has_room, issue, fill, pop, dropping;

   // dropped responses still occupy a slot of memory's outstanding window
   assign has_room       = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH);
   assign imem_req_valid = ~reset & ~hold & ~redirect_valid & has_room;
   assign imem_req_addr  = pc;
   assign issue          = imem_req_valid & imem_req_ready;

   assign dropping = imem_rsp_valid & (drop_cnt != '0);
   assign fill     = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;

   assign dec_valid   = ~reset & head.filled;
   assign pop         = dec_valid & dec_ready & ~redirect_valid;
   assign dec_instr   = head.instr;
   assign dec_pc      = head.pc[AW-1:0];
   assign dec_pcplus4 = dec_pc + AW'(PC_STEP);

   assign unfilled = alloc_cnt - filled_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         alloc_cnt <= '0;
         drop_cnt  <= '0;
      end else if (redirect_valid) begin
         // every unfilled entry becomes a stale response; one may land this cycle
         pc        <= redirect_pc;
         alloc_cnt <= '0;
         drop_cnt  <= drop_cnt + unfilled - CW'(imem_rsp_valid);
      end else begin
         if (issue) pc <= pc + AW'(PC_STEP);
         alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
         if (dropping) drop_cnt <= drop_cnt - CW'(1);
      end
   end

   fetch_ring #(.DEPTH(DEPTH), .AW(AW)) u_ring (
      .clk        (clk),
      .reset      (reset),
      .clear      (redirect_valid),
      .alloc      (issue),
      .alloc_pc   (pc),
      .fill       (fill),
      .fill_instr (imem_rsp_data),
      .pop        (pop),
      .head       (head),
      .filled_cnt (filled_cnt)
   );

   a_window: assert property (@(posedge clk) disable iff (reset)
      ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) <= (CW+1)'(DEPTH));
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> ((unfilled + drop_cnt) != '0));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order memory model.
module tb_fetch_queue;
   localparam int          AW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h100;
   localparam logic [31:0] PAT   = 32'h5A5A_0000;

   logic          clk = 1'b0, reset = 1'b1;
   logic          imem_req_valid, imem_req_ready = 1'b1;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [31:0]   imem_rsp_data;
   logic          hold = 1'b0, redirect_valid = 1'b0, dec_ready = 1'b1;
   logic [AW-1:0] redirect_pc = '0;
   logic          dec_valid;
   logic [31:0]   dec_instr;
   logic [AW-1:0] dec_pc, dec_pcplus4;

   always #5 clk = ~clk;

   fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .hold(hold),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .dec_pcplus4(dec_pcplus4)
   );

   int total = 0, bad = 0;
   int lat = 1;
   logic [31:0] cyc = '0;
   logic [31:0] acc_addr[$], acc_cyc[$];
   logic [31:0] pop_pc[$], pop_p4[$], pop_instr[$], pop_cyc[$];
   logic [31:0] mem_addr[$], mem_due[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // memory model plus logs of accepted requests and decode pops
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr.delete();
         mem_due.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            mem_addr.push_back(imem_req_addr);
            mem_due.push_back(cyc + lat);
            acc_addr.push_back(imem_req_addr);
            acc_cyc.push_back(cyc);
         end
         if (dec_valid && dec_ready && !redirect_valid) begin
            pop_pc.push_back(dec_pc);
            pop_p4.push_back(dec_pcplus4);
            pop_instr.push_back(dec_instr);
            pop_cyc.push_back(cyc);
         end
         if (mem_due.size() > 0 && mem_due[0] == cyc + 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_addr[0] ^ PAT;
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
         end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      acc_addr.delete(); acc_cyc.delete();
      pop_pc.delete(); pop_p4.delete(); pop_instr.delete(); pop_cyc.delete();
   endtask

   task automatic do_reset(input int l);
      @(negedge clk);
      reset = 1'b1; lat = l; hold = 1'b0; redirect_valid = 1'b0;
      dec_ready = 1'b1; imem_req_ready = 1'b1;
      clear_logs();
      tick(2);
      reset = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target, output logic [31:0] rc,
                           output int nacc, output int npop);
      redirect_valid = 1'b1; redirect_pc = target;
      rc = cyc; nacc = acc_addr.size(); npop = pop_pc.size();
   endtask

   initial begin
      logic [31:0] rc;
      int nacc, npop;

      // reset state
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_dec_valid", dec_valid, 0);

      // streaming at L=1
      do_reset(1);
      tick(10);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", at(acc_addr, i), RPC + 32'(4 * i));
         chk("t1_acc_gap", at(acc_cyc, i) - at(acc_cyc, 0), i);
      end
      chk("t1_latency", at(pop_cyc, 0) - at(acc_cyc, 0), 2);
      chk("t1_pc", at(pop_pc, 0), 32'h100);
      chk("t1_pcplus4", at(pop_p4, 0), 32'h104);
      chk("t1_instr", at(pop_instr, 0), 32'h100 ^ PAT);
      chk("t1_rate", at(pop_cyc, 3) - at(pop_cyc, 0), 3);

      // decode stalled: queue fills to DEPTH then drains in order
      do_reset(1);
      dec_ready = 1'b0;
      tick(10);
      chk("t2_nacc", acc_addr.size(), 4);
      chk("t2_full_req", imem_req_valid, 0);
      chk("t2_head_valid", dec_valid, 1);
      chk("t2_nopop", pop_pc.size(), 0);
      dec_ready = 1'b1;
      tick(8);
      for (int i = 0; i < 4; i++) chk("t2_drain", at(pop_pc, i), RPC + 32'(4 * i));
      chk("t2_resume", at(acc_addr, 4), 32'h110);

      // L=3 redirect with three requests in flight
      do_reset(3);
      tick(3);
      redirect(32'h400, rc, nacc, npop);
      #1 chk("t3_req_blocked", imem_req_valid, 0);
      tick(1);
      redirect_valid = 1'b0;
      tick(14);
      chk("t3_nacc_old", nacc, 3);
      chk("t3_new_addr", at(acc_addr, nacc), 32'h400);
      chk("t3_new_cyc", at(acc_cyc, nacc), rc + 1);
      chk("t3_no_stale", pop_pc.size() > npop ? at(pop_pc, npop) : 32'hx, 32'h400);
      chk("t3_pop_cyc", at(pop_cyc, npop), rc + 5);
      chk("t3_instr", at(pop_instr, npop), 32'h400 ^ PAT);
      chk("t3_second", at(pop_pc, npop + 1), 32'h404);

      // redirect coinciding with response, pop and ready request
      do_reset(1);
      tick(6);
      redirect(32'h400, rc, nacc, npop);
      #1;
      chk("t4_req_blocked", imem_req_valid, 0);
      chk("t4_head_valid", dec_valid, 1);
      chk("t4_rsp_present", imem_rsp_valid, 1);
      tick(1);
      redirect_valid = 1'b0;
      #1 chk("t4_dv_r1", dec_valid, 0);
      tick(1);
      chk("t4_dv_r2", dec_valid, 0);
      tick(5);
      chk("t4_new_addr", at(acc_addr, nacc), 32'h400);
      chk("t4_new_cyc", at(acc_cyc, nacc), rc + 1);
      chk("t4_first_pop", at(pop_pc, npop), 32'h400);
      chk("t4_pop_cyc", at(pop_cyc, npop), rc + 3);

      // PC wrap past the top of the address space
      do_reset(1);
      tick(2);
      redirect(32'hFFFF_FFFC, rc, nacc, npop);
      tick(1);
      redirect_valid = 1'b0;
      tick(8);
      chk("t5_addr0", at(acc_addr, nacc), 32'hFFFF_FFFC);
      chk("t5_addr1", at(acc_addr, nacc + 1), 32'h0);
      chk("t5_pc0", at(pop_pc, npop), 32'hFFFF_FFFC);
      chk("t5_p4_0", at(pop_p4, npop), 32'h0);
      chk("t5_pc1", at(pop_pc, npop + 1), 32'h0);
      chk("t5_p4_1", at(pop_p4, npop + 1), 32'h4);

      // asynchronous reset mid-stream
      do_reset(1);
      tick(6);
      chk("t6_pre_dv", dec_valid, 1);
      chk("t6_pre_req", imem_req_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_dv", dec_valid, 0);
      chk("t6_async_req", imem_req_valid, 0);
      @(negedge clk);
      clear_logs();
      reset = 1'b0;
      tick(4);
      chk("t6_first_addr", at(acc_addr, 0), RPC);
      chk("t6_first_pop", at(pop_pc, 0), RPC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
